// File: rtl/icache_tag_array_pkg.sv
// Shared instruction-cache geometry constants used by the tag array, data array and controller.
package icache_tag_array_pkg;

    localparam int ICACHE_NUM_SETS = 64;
    localparam int ICACHE_INDEX_W  = 6;
    localparam int ICACHE_TAG_W    = 22;
    localparam int ICACHE_WORD_W   = 2;
    // Byte offset within a line: whatever the 32-bit address has left after tag, index and word bits.
    localparam int ICACHE_OFFSET_W = 32 - ICACHE_TAG_W - ICACHE_INDEX_W - ICACHE_WORD_W;

endpackage

// File: rtl/icache_tag_array.sv
// Direct-mapped icache tag store: one tag plus valid bit per set, with a combinational hit,
// single-port tag fill and a one-cycle whole-cache invalidate.
module icache_tag_array
    import icache_tag_array_pkg::*;
#(
    parameter int NUM_SETS = ICACHE_NUM_SETS,
    parameter int INDEX_W  = ICACHE_INDEX_W,
    parameter int TAG_W    = ICACHE_TAG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] lookup_index,
    input  logic [TAG_W-1:0]   lookup_tag,
    output logic               hit,
    input  logic               update_valid,
    input  logic [INDEX_W-1:0] update_index,
    input  logic [TAG_W-1:0]   update_tag,
    input  logic               flush_all
);

    logic [NUM_SETS-1:0] valid_r;
    logic [TAG_W-1:0]    tag_mem_r [NUM_SETS];
    logic                write_en_s;

    // A fill is only committed when neither reset (rst_n high) nor flush overrides it.
    always_comb begin
        write_en_s = 1'b0;
        if ((update_valid == 1'b1) && (rst_n == 1'b0) && (flush_all == 1'b0)) begin
            write_en_s = 1'b1;
        end else begin
            write_en_s = 1'b0;
        end
    end

    // Valid bits: reset and flush both invalidate everything, otherwise a fill marks its set valid.
    always_ff @(posedge clk) begin
        if (rst_n == 1'b1) begin
            valid_r <= '0;
        end else if (flush_all == 1'b1) begin
            valid_r <= '0;
        end else if (write_en_s == 1'b1) begin
            valid_r[update_index] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag storage has no reset so it can map onto sync-write/async-read LUTRAM.
    always_ff @(posedge clk) begin
        if (write_en_s == 1'b1) begin
            tag_mem_r[update_index] <= update_tag;
        end
    end

    // Lookup reads the current array state with no bypass from a same-cycle fill.
    always_comb begin
        hit = 1'b0;
        if (valid_r[lookup_index] == 1'b1) begin
            hit = (tag_mem_r[lookup_index] == lookup_tag);
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: tb/tb_icache_tag_array.sv
// Directed self-checking bench for icache_tag_array with hand-computed hit expectations.
module tb_icache_tag_array;

    localparam int IW = 6;
    localparam int TW = 22;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [IW-1:0] lookup_index = '0;
    logic [TW-1:0] lookup_tag = '0;
    logic          hit;
    logic          update_valid = 1'b0;
    logic [IW-1:0] update_index = '0;
    logic [TW-1:0] update_tag = '0;
    logic          flush_all = 1'b0;

    int passed = 0;
    int total  = 0;

    icache_tag_array dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_index (lookup_index),
        .lookup_tag   (lookup_tag),
        .hit          (hit),
        .update_valid (update_valid),
        .update_index (update_index),
        .update_tag   (update_tag),
        .flush_all    (flush_all)
    );

    always #5 clk = ~clk;

    // Apply a lookup mid-cycle and compare the combinational hit.
    task automatic probe(input string name, input logic [IW-1:0] idx, input logic [TW-1:0] t,
                         input logic expected);
        lookup_index = idx;
        lookup_tag   = t;
        #1;
        total++;
        assert (hit === expected) passed++;
        else $error("FAIL %s idx=%0d tag=%h: hit=%b expected %b", name, idx, t, hit, expected);
    endtask

    task automatic check(input string name, input logic [IW-1:0] idx, input logic [TW-1:0] t,
                         input logic expected);
        @(negedge clk);
        probe(name, idx, t, expected);
    endtask

    task automatic write(input logic [IW-1:0] idx, input logic [TW-1:0] t);
        @(negedge clk);
        update_valid = 1'b1;
        update_index = idx;
        update_tag   = t;
        @(posedge clk);
        #1;
        update_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush_all = 1'b1;
        @(posedge clk);
        #1;
        flush_all = 1'b0;
    endtask

    initial begin
        // Reset held for two edges.
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 64; i++) check("reset_miss", IW'(i), 22'h0ABCDE, 1'b0);

        // Single write.
        write(6'd10, 22'h012345);
        check("single_hit", 6'd10, 22'h012345, 1'b1);
        check("single_wrong_tag", 6'd10, 22'h054321, 1'b0);
        check("single_other_idx", 6'd11, 22'h012345, 1'b0);

        // Multi-write then flush.
        for (int i = 0; i < 10; i++) write(IW'(i), TW'(32'h10000 + i));
        for (int i = 0; i < 10; i++) check("multi_hit", IW'(i), TW'(32'h10000 + i), 1'b1);
        pulse_flush();
        for (int i = 0; i < 10; i++) check("flush_miss", IW'(i), TW'(32'h10000 + i), 1'b0);
        check("flush_miss_idx10", 6'd10, 22'h012345, 1'b0);

        // Overwrite replaces the tag.
        write(6'd20, 22'h2AAAAA);
        check("ow_first_hit", 6'd20, 22'h2AAAAA, 1'b1);
        write(6'd20, 22'h3BBBBB);
        check("ow_old_miss", 6'd20, 22'h2AAAAA, 1'b0);
        check("ow_new_hit", 6'd20, 22'h3BBBBB, 1'b1);

        // Full array, each index with its own tag.
        for (int i = 0; i < 64; i++) write(IW'(i), TW'(32'h20000 + i));
        for (int i = 0; i < 64; i++) begin
            check("full_hit", IW'(i), TW'(32'h20000 + i), 1'b1);
            check("full_neighbor_miss", IW'(i), TW'(32'h20000 + ((i + 1) % 64)), 1'b0);
        end

        // Flush and update in the same cycle: flush wins and the write is dropped.
        @(negedge clk);
        flush_all    = 1'b1;
        update_valid = 1'b1;
        update_index = 6'd31;
        update_tag   = 22'h155555;
        @(posedge clk);
        #1;
        flush_all    = 1'b0;
        update_valid = 1'b0;
        check("flush_upd_new_miss", 6'd31, 22'h155555, 1'b0);
        check("flush_upd_old_miss", 6'd31, TW'(32'h20000 + 31), 1'b0);
        check("flush_upd_other_miss", 6'd30, TW'(32'h20000 + 30), 1'b0);

        // No same-cycle bypass: lookup during the write cycle sees the old entry.
        write(6'd40, 22'h0D0D0D);
        @(negedge clk);
        update_valid = 1'b1;
        update_index = 6'd40;
        update_tag   = 22'h0C0C0C;
        probe("wcycle_new_miss", 6'd40, 22'h0C0C0C, 1'b0);
        probe("wcycle_old_hit", 6'd40, 22'h0D0D0D, 1'b1);
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        probe("after_write_new_hit", 6'd40, 22'h0C0C0C, 1'b1);
        probe("after_write_old_miss", 6'd40, 22'h0D0D0D, 1'b0);

        // Reset during an update: entry stays invalid and other valids are cleared.
        @(negedge clk);
        rst_n        = 1'b1;
        update_valid = 1'b1;
        update_index = 6'd50;
        update_tag   = 22'h0EEEEE;
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        update_valid = 1'b0;
        check("rst_upd_miss", 6'd50, 22'h0EEEEE, 1'b0);
        check("rst_clears_other", 6'd40, 22'h0C0C0C, 1'b0);

        // Array still works after the mid-operation reset.
        write(6'd63, 22'h3FFFFF);
        check("post_rst_hit", 6'd63, 22'h3FFFFF, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
